// File: rtl/packet_queue.sv
// Round-robin merge of loader (PL) and matching-unit (MA) packets into one FIFO feeding the executor.
// Optional same-cycle bypass of an empty queue: define PACKET_QUEUE_BYPASS_EN.
module packet_queue #(
   parameter int PACKET_WIDTH = 175,
   parameter int DEPTH        = 8,
   parameter int ADDR_WIDTH   = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    RECEIVE_PC_FROM_PL_VALID,
   input  logic [PACKET_WIDTH-1:0] RECEIVE_PC_FROM_PL_DATA,
   output logic                    RECEIVE_PC_FROM_PL_READY,
   input  logic                    RECEIVE_PC_FROM_MA_VALID,
   input  logic [PACKET_WIDTH-1:0] RECEIVE_PC_FROM_MA_DATA,
   output logic                    RECEIVE_PC_FROM_MA_READY,
   output logic                    SEND_PC_VALID,
   output logic [PACKET_WIDTH-1:0] SEND_PC_DATA,
   input  logic                    SEND_PC_READY
);

   typedef enum logic {PRIO_PL = 1'b0, PRIO_MA = 1'b1} prio_e;

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   prio_e                   prio_q, prio_d;

   logic                    full;
   logic                    empty;
   logic                    pl_grant;
   logic                    ma_grant;
   logic                    wr_grant;
   logic                    bypass;
   logic                    wr_en;
   logic                    rd_en;
   logic [PACKET_WIDTH-1:0] wr_data;

   always_comb begin
      full  = (count_q == FULL_COUNT);
      empty = (count_q == '0);

      // READY looks only at input VALIDs and registered state, never at SEND_PC_READY.
      pl_grant = !RST && !full && RECEIVE_PC_FROM_PL_VALID &&
                 (!RECEIVE_PC_FROM_MA_VALID || (prio_q == PRIO_PL));
      ma_grant = !RST && !full && RECEIVE_PC_FROM_MA_VALID &&
                 (!RECEIVE_PC_FROM_PL_VALID || (prio_q == PRIO_MA));
      wr_grant = pl_grant || ma_grant;
      wr_data  = pl_grant ? RECEIVE_PC_FROM_PL_DATA : RECEIVE_PC_FROM_MA_DATA;

      RECEIVE_PC_FROM_PL_READY = pl_grant;
      RECEIVE_PC_FROM_MA_READY = ma_grant;

`ifdef PACKET_QUEUE_BYPASS_EN
      bypass = wr_grant && empty && SEND_PC_READY;
`else
      bypass = 1'b0;
`endif

      wr_en = wr_grant && !bypass;
      rd_en = !RST && !empty && SEND_PC_READY;

      SEND_PC_VALID = !RST && (!empty || bypass);
      SEND_PC_DATA  = bypass ? wr_data : mem_q[rd_ptr_q];

      wr_ptr_d = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase

      // Priority flips to the other source only after a granted packet, bypassed or stored.
      prio_d = prio_q;
      if (wr_grant) begin
         prio_d = pl_grant ? PRIO_MA : PRIO_PL;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         prio_q   <= PRIO_PL;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         prio_q   <= prio_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_packet_queue.sv
// Directed self-checking bench for packet_queue: reset, fill/drain, arbitration, streaming, mid-stream reset, bypass.
module tb_packet_queue;

   localparam int PW = 175;

   logic          clk = 1'b0;
   logic          rst;
   logic          pl_valid;
   logic [PW-1:0] pl_data;
   logic          pl_ready;
   logic          ma_valid;
   logic [PW-1:0] ma_data;
   logic          ma_ready;
   logic          send_valid;
   logic [PW-1:0] send_data;
   logic          send_ready;

   int checks = 0;
   int errors = 0;

   packet_queue #(.PACKET_WIDTH(PW), .DEPTH(8), .ADDR_WIDTH(3)) dut (
      .CLK                      (clk),
      .RST                      (rst),
      .RECEIVE_PC_FROM_PL_VALID (pl_valid),
      .RECEIVE_PC_FROM_PL_DATA  (pl_data),
      .RECEIVE_PC_FROM_PL_READY (pl_ready),
      .RECEIVE_PC_FROM_MA_VALID (ma_valid),
      .RECEIVE_PC_FROM_MA_DATA  (ma_data),
      .RECEIVE_PC_FROM_MA_READY (ma_ready),
      .SEND_PC_VALID            (send_valid),
      .SEND_PC_DATA             (send_data),
      .SEND_PC_READY            (send_ready)
   );

   always #5 clk = ~clk;

   // Tag in the low byte, inverted nibble at the top so the full width is exercised.
   function automatic logic [PW-1:0] pkt(input logic [7:0] tag);
      return {~tag[3:0], 163'h1_0000_0000_0000_0005, tag};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      pl_valid = 1'b0;
      ma_valid = 1'b0;
      send_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pl_valid = 1'b1;
      ma_valid = 1'b1;
      pl_data = pkt(8'h11);
      ma_data = pkt(8'h22);
      send_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (pl_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_pl_ready: got %b expected 0", pl_ready);
      end
      checks++;
      if (ma_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ma_ready: got %b expected 0", ma_ready);
      end
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_send_valid: got %b expected 0", send_valid);
      end
      rst = 1'b0;
      ma_valid = 1'b0;
      pl_data = pkt(8'hA5);
      #1;
      checks++;
      if (pl_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 1", pl_ready);
      end
      tick();
      pl_valid = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b1 || send_data !== pkt(8'hA5)) begin
         errors++;
         $display("FAIL first_packet: valid %b data %h expected valid 1 data %h", send_valid, send_data, pkt(8'hA5));
      end
      send_ready = 1'b1;
      tick();
      send_ready = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_packet_drained: got %b expected 0", send_valid);
      end
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         pl_valid = 1'b1;
         pl_data = pkt(8'(i));
         #1;
         checks++;
         if (pl_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready[%0d]: got %b expected 1", i, pl_ready);
         end
         tick();
      end
      pl_data = pkt(8'h08);
      ma_valid = 1'b1;
      ma_data = pkt(8'h99);
      #1;
      checks++;
      if (pl_ready !== 1'b0 || ma_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: pl %b ma %b expected 0 0", pl_ready, ma_ready);
      end
      ma_valid = 1'b0;
      tick();
      checks++;
      if (send_data !== pkt(8'h00)) begin
         errors++;
         $display("FAIL head_stable: got %h expected %h", send_data, pkt(8'h00));
      end
      // Pop while full: no write this cycle, READY returns after the pop.
      send_ready = 1'b1;
      #1;
      checks++;
      if (pl_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_ready: got %b expected 0", pl_ready);
      end
      tick();
      checks++;
      if (pl_ready !== 1'b1 || send_data !== pkt(8'h01)) begin
         errors++;
         $display("FAIL after_pop: ready %b data %h expected ready 1 data %h", pl_ready, send_data, pkt(8'h01));
      end
      tick();
      pl_valid = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         #1;
         checks++;
         if (send_valid !== 1'b1 || send_data !== pkt(8'(i))) begin
            errors++;
            $display("FAIL drain[%0d]: valid %b data %h expected valid 1 data %h", i, send_valid, send_data, pkt(8'(i)));
         end
         tick();
      end
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: got %b expected 0", send_valid);
      end
      send_ready = 1'b0;
   endtask

   task automatic test_arbitration();
      logic [PW-1:0] got [$];
      logic [PW-1:0] exp_q [$];
      int pl_idx;
      int ma_idx;
      logic pr;
      logic mr;
      apply_reset();
      send_ready = 1'b1;
      pl_idx = 0;
      ma_idx = 0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(pkt(8'h10 + 8'(i)));
         exp_q.push_back(pkt(8'h20 + 8'(i)));
      end
      for (int cyc = 0; cyc < 14; cyc++) begin
         pl_valid = (pl_idx < 4);
         ma_valid = (ma_idx < 4);
         pl_data = pkt(8'h10 + 8'(pl_idx));
         ma_data = pkt(8'h20 + 8'(ma_idx));
         #1;
         pr = pl_ready;
         mr = ma_ready;
         if (pl_valid && ma_valid) begin
            checks++;
            if ((pr ^ mr) !== 1'b1) begin
               errors++;
               $display("FAIL arb_one_grant[%0d]: pl %b ma %b expected exactly one", cyc, pr, mr);
            end
         end
         if (send_valid === 1'b1) got.push_back(send_data);
         tick();
         if (pr === 1'b1) pl_idx++;
         if (mr === 1'b1) ma_idx++;
      end
      pl_valid = 1'b0;
      ma_valid = 1'b0;
      checks++;
      if (got.size() !== 8) begin
         errors++;
         $display("FAIL arb_count: got %0d packets expected 8", got.size());
      end
      for (int i = 0; i < 8; i++) begin
         if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL arb_order[%0d]: got %h expected %h", i, got[i], exp_q[i]);
            end
         end
      end
      send_ready = 1'b0;
   endtask

   task automatic test_push_pop();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         pl_valid = 1'b1;
         pl_data = pkt(8'h30 + 8'(i));
         tick();
      end
      send_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pl_data = pkt(8'h34 + 8'(i));
         #1;
         checks++;
         if (pl_ready !== 1'b1 || send_valid !== 1'b1 || send_data !== pkt(8'h30 + 8'(i))) begin
            errors++;
            $display("FAIL stream[%0d]: ready %b valid %b data %h expected 1 1 %h", i, pl_ready, send_valid, send_data, pkt(8'h30 + 8'(i)));
         end
         tick();
      end
      pl_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (send_valid !== 1'b1 || send_data !== pkt(8'h44 + 8'(k))) begin
            errors++;
            $display("FAIL stream_tail[%0d]: valid %b data %h expected 1 %h", k, send_valid, send_data, pkt(8'h44 + 8'(k)));
         end
         tick();
      end
      tick();
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_empty: got %b expected 0", send_valid);
      end
      send_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         pl_valid = 1'b1;
         pl_data = pkt(8'h60 + 8'(i));
         tick();
      end
      pl_valid = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_queued: got %b expected 1", send_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_valid: got %b expected 0", send_valid);
      end
      ma_valid = 1'b1;
      ma_data = pkt(8'h70);
      #1;
      checks++;
      if (ma_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_push_ready: got %b expected 1", ma_ready);
      end
      tick();
      ma_valid = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b1 || send_data !== pkt(8'h70)) begin
         errors++;
         $display("FAIL mid_next: valid %b data %h expected 1 %h", send_valid, send_data, pkt(8'h70));
      end
      send_ready = 1'b1;
      tick();
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_old_gone: got %b expected 0", send_valid);
      end
      send_ready = 1'b0;
   endtask

   task automatic test_bypass();
      apply_reset();
      send_ready = 1'b1;
      ma_valid = 1'b1;
      ma_data = pkt(8'h3C);
      #1;
      checks++;
      if (ma_ready !== 1'b1) begin
         errors++;
         $display("FAIL bypass_ready: got %b expected 1", ma_ready);
      end
`ifdef PACKET_QUEUE_BYPASS_EN
      checks++;
      if (send_valid !== 1'b1 || send_data !== pkt(8'h3C)) begin
         errors++;
         $display("FAIL bypass_same_cycle: valid %b data %h expected 1 %h", send_valid, send_data, pkt(8'h3C));
      end
      tick();
      ma_valid = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_not_stored: got %b expected 0", send_valid);
      end
`else
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_passthrough: got %b expected 0", send_valid);
      end
      tick();
      ma_valid = 1'b0;
      #1;
      checks++;
      if (send_valid !== 1'b1 || send_data !== pkt(8'h3C)) begin
         errors++;
         $display("FAIL one_cycle_latency: valid %b data %h expected 1 %h", send_valid, send_data, pkt(8'h3C));
      end
      tick();
      checks++;
      if (send_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_drained: got %b expected 0", send_valid);
      end
`endif
      send_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pl_valid = 1'b0;
      ma_valid = 1'b0;
      pl_data = '0;
      ma_data = '0;
      send_ready = 1'b0;
      test_reset();
      test_fill();
      test_arbitration();
      test_push_pop();
      test_reset_mid();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/packet_queue.md
Name: packet_queue

Overview:
- Packet buffer directly downstream of packet_loader's SEND_PC_TO_QU port. It also merges packets returned by the matching unit.
- Arbitrates two packet sources round-robin into one PACKET_WIDTH-wide FIFO, at most one write per cycle.
- Presents the FIFO head to the executor through a valid/ready output port.
- Decouples the loader's memory latency from execution throughput.

Parameters:
- PACKET_WIDTH, 175, packet bit width (5×32 + 15, same as packet_loader output).
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- RECEIVE_PC_FROM_PL_VALID  in  1  packet from packet_loader valid.
- RECEIVE_PC_FROM_PL_DATA  in  PACKET_WIDTH  packet from packet_loader.
- RECEIVE_PC_FROM_PL_READY  out  1  packet accepted from loader this cycle.
- RECEIVE_PC_FROM_MA_VALID  in  1  packet from matching unit valid.
- RECEIVE_PC_FROM_MA_DATA  in  PACKET_WIDTH  packet from matching unit.
- RECEIVE_PC_FROM_MA_READY  out  1  packet accepted from matching unit this cycle.
- SEND_PC_VALID  out  1  FIFO head valid.
- SEND_PC_DATA  out  PACKET_WIDTH  FIFO head packet.
- SEND_PC_READY  in  1  executor consumes head.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - wr_ptr, rd_ptr and count are cleared to 0.
  - Round-robin priority is set to PL.
  - Contents are discarded, including on reset mid-stream.
  - While RST=1, both READYs and SEND_PC_VALID are 0. SEND_PC_DATA is don't-care while SEND_PC_VALID=0.
- Handshake:
  - A transfer occurs on a rising edge where VALID && READY.
  - Sources must hold VALID and DATA until accepted; the queue never drops or duplicates a packet.
  - READY may depend combinationally on the input VALIDs and on registered state. READY never depends on SEND_PC_READY (no full-pass-through).
- Arbitration:
  - full = (count == DEPTH).
  - If full, both READYs are 0.
  - Else, if exactly one source is valid, that source's READY is 1.
  - Else, if both are valid, only the priority source's READY is 1.
  - After a granted write, priority moves to the other source. Priority is unchanged when no write occurs.
  - READY of a non-valid source is 0.
- Write: the accepted packet is stored at mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap at ADDR_WIDTH bits).
- Read:
  - SEND_PC_VALID = (count != 0); SEND_PC_DATA = mem[rd_ptr].
  - On SEND_PC_VALID && SEND_PC_READY, rd_ptr increments modulo DEPTH.
- Count:
  - count is ADDR_WIDTH+1 bits.
  - Write only: +1. Read only: −1. Simultaneous write and read: unchanged, and both pointers advance.
- Latency: a packet written at edge N is visible on SEND_PC_* after edge N (1 cycle) when the queue was empty.
- Ordering: strict FIFO by acceptance order across both sources.
- Boundaries:
  - Full with a read in the same cycle: no write that cycle. READY is 0 and stays low until the edge after the pop.
  - Empty: SEND_PC_READY is ignored.
  - SEND_PC_DATA is stable while SEND_PC_VALID=1 and not consumed.

Optional Feature:
- Macro: PACKET_QUEUE_BYPASS_EN.
- Defined: when count==0 and SEND_PC_READY==1, the granted input packet drives SEND_PC_DATA with SEND_PC_VALID=1 in the same cycle (0-cycle latency).
  - Such a packet is not written to the FIFO; pointers and count are unchanged.
  - Arbitration and priority update are identical to the non-bypass case.
- Undefined: no combinational input-to-output path; minimum latency is 1 cycle.

Test Plan:
- Reset: hold RST=1 with both input VALIDs=1 -> both READYs=0 and SEND_PC_VALID=0. Release RST -> a PL packet 0x…A5 is accepted on the first edge and appears on SEND_PC_DATA after 1 cycle (bypass off).
- Fill: SEND_PC_READY=0, push 8 PL packets with DATA = index 0..7 -> READY drops after the 8th. Then assert SEND_PC_READY -> outputs 0..7 in order, then SEND_PC_VALID=0.
- Arbitration: both sources valid continuously with PL packets P0..P3 and MA packets M0..M3, SEND_PC_READY=1 -> output order P0,M0,P1,M1,P2,M2,P3,M3.
- Simultaneous push/pop: hold count at 4 with streaming in and out for 20 cycles -> count remains 4, no loss. Pointers wrap past 7 -> 0 with correct data.
- Reset mid-operation: 5 entries queued, pulse RST for 1 cycle -> SEND_PC_VALID=0 after the edge. The next pushed packet is the next one output, and the old entries never appear.
- Bypass (PACKET_QUEUE_BYPASS_EN defined): empty queue, SEND_PC_READY=1, MA sends 0x…3C -> SEND_PC_VALID=1 with that data in the same cycle; count stays 0.
